// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers four BCD digits from a scanned, multiplexed 7-segment display
// Optional feature macro: SEG7_SCAN_DECODER_ERR_EN (sticky illegal-pattern and overrun flags on err).
module seg7_scan_decoder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_n,
    output logic [15:0] bcd_out,
    output logic        valid,
    input  logic        ready,
    output logic [4:0]  err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam logic [7:0] SETTLE_C = SETTLE[7:0];

    // capture FSM
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;

    // frame assembly
    logic [15:0] slots_q, slots_d;
    logic [3:0]  seen_q, seen_d;

    // frame qualification and presentation
    logic [15:0] prev_q, prev_d;
    logic        prev_vld_q, prev_vld_d;
    logic [15:0] last_q, last_d;
    logic        last_vld_q, last_vld_d;
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;

    logic [3:0]  dec;
    logic        single_sel;
    logic [1:0]  sel_idx;
    logic        sample;
    logic        frame_done;
    logic        qualify;
    logic        present;
    logic        overrun;

    // Segment pattern to BCD; anything outside the ten digit shapes reads as 4'hF.
    always_comb begin
        dec = 4'hF;
        case (seg_in)
            7'b0000001: dec = 4'd0;
            7'b1001111: dec = 4'd1;
            7'b0010010: dec = 4'd2;
            7'b0000110: dec = 4'd3;
            7'b1001100: dec = 4'd4;
            7'b0100100: dec = 4'd5;
            7'b0100000: dec = 4'd6;
            7'b0001111: dec = 4'd7;
            7'b0000000: dec = 4'd8;
            7'b0000100: dec = 4'd9;
            default:    dec = 4'hF;
        endcase
    end

    // Exactly one select line low; the held select is turned into a slot index.
    always_comb begin
        single_sel = 1'b0;
        case (dig_n)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_sel = 1'b1;
            default:                             single_sel = 1'b0;
        endcase
        sel_idx = 2'd0;
        case (sel_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    // Capture FSM: wait for a steady single select, sample once after SETTLE cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (single_sel) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd0;
                    sel_d   = dig_n;
                end
            end
            ST_SETTLE: begin
                if (dig_n != sel_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == SETTLE_C) begin
                        sample  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (dig_n != sel_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot writes and seen mask; a full mask closes the frame one cycle later and restarts the mask.
    always_comb begin
        frame_done = (seen_q == 4'hF);
        slots_d    = slots_q;
        seen_d     = frame_done ? 4'h0 : seen_q;
        if (sample) begin
            slots_d[{sel_idx, 2'b00} +: 4] = dec;
            seen_d[sel_idx]                = 1'b1;
        end
    end

    // Two identical consecutive frames qualify; only a change from the last presented frame is shown.
    always_comb begin
        qualify    = frame_done && prev_vld_q && (slots_q == prev_q);
        present    = qualify && (!last_vld_q || (slots_q != last_q));
        overrun    = present && valid_q && !ready;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        bcd_d      = bcd_q;
        valid_d    = valid_q;
        if (frame_done) begin
            prev_d     = slots_q;
            prev_vld_d = 1'b1;
        end
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (present && !overrun) begin
            bcd_d      = slots_q;
            valid_d    = 1'b1;
            last_d     = slots_q;
            last_vld_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            sel_q      <= 4'hF;
            slots_q    <= 16'h0000;
            seen_q     <= 4'h0;
            prev_q     <= 16'h0000;
            prev_vld_q <= 1'b0;
            last_q     <= 16'h0000;
            last_vld_q <= 1'b0;
            bcd_q      <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            slots_q    <= slots_d;
            seen_q     <= seen_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
        end
    end

    assign bcd_out = bcd_q;
    assign valid   = valid_q;

`ifdef SEG7_SCAN_DECODER_ERR_EN
    logic [4:0] err_q, err_d;

    // Sticky flags: illegal pattern per digit slot, and a dropped frame on overrun.
    always_comb begin
        err_d = err_q;
        if (sample && (dec == 4'hF)) begin
            err_d[sel_idx] = 1'b1;
        end
        if (overrun) begin
            err_d[4] = 1'b1;
        end
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 5'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 5'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed-vector bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

`ifdef SEG7_SCAN_DECODER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_n;
    logic [15:0] bcd_out;
    logic        valid;
    logic        ready;
    logic [4:0]  err;

    int          n_vec;
    int          n_bad;
    int          acc_cnt;
    logic [15:0] acc_bcd;

    seg7_scan_decoder #(.SETTLE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_in  (seg_in),
        .dig_n   (dig_n),
        .bcd_out (bcd_out),
        .valid   (valid),
        .ready   (ready),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor on the falling edge.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            acc_cnt = acc_cnt + 1;
            acc_bcd = bcd_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    enc = 7'b0000001;
            4'd1:    enc = 7'b1001111;
            4'd2:    enc = 7'b0010010;
            4'd3:    enc = 7'b0000110;
            4'd4:    enc = 7'b1001100;
            4'd5:    enc = 7'b0100100;
            4'd6:    enc = 7'b0100000;
            4'd7:    enc = 7'b0001111;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0000100;
            default: enc = 7'b1111111;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dig_n  = 4'hF;
        seg_in = 7'h7F;
        repeat (n) cyc();
    endtask

    task automatic scan(input logic [15:0] f, input int dwell, input int ndig);
        logic [3:0] one;
        one = 4'b0001;
        for (int d = 0; d < ndig; d++) begin
            dig_n  = ~(one << d);
            seg_in = enc(f[d*4 +: 4]);
            repeat (dwell) cyc();
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        acc_cnt = 0;
        acc_bcd = 16'h0;
        rst_n   = 1'b0;
        ready   = 1'b1;
        dig_n   = 4'hF;
        seg_in  = 7'h7F;

        repeat (3) cyc();
        chk("rst_bcd", bcd_out, 16'h0000);
        chk("rst_valid", valid, 1'b0);
        chk("rst_err", err, 5'b0);
        rst_n = 1'b1;
        idle(2);

        // short dwell never samples
        scan(16'h4321, 3, 4);
        scan(16'h4321, 3, 4);
        idle(4);
        chk("short_seen", dut.seen_q, 4'h0);
        chk("short_acc", acc_cnt, 0);
        chk("short_valid", valid, 1'b0);

        // two identical scans qualify once
        scan(16'h4321, 6, 4);
        idle(4);
        chk("one_scan_acc", acc_cnt, 0);
        scan(16'h4321, 6, 4);
        idle(4);
        chk("two_scan_acc", acc_cnt, 1);
        chk("two_scan_bcd", acc_bcd, 16'h4321);
        chk("hold_bcd", bcd_out, 16'h4321);
        chk("drop_valid", valid, 1'b0);

        // repeats of the same frame are suppressed
        repeat (5) scan(16'h4321, 6, 4);
        idle(4);
        chk("repeat_acc", acc_cnt, 1);
        scan(16'h4921, 6, 4);
        idle(4);
        chk("chg1_acc", acc_cnt, 1);
        scan(16'h4921, 6, 4);
        idle(4);
        chk("chg2_acc", acc_cnt, 2);
        chk("chg2_bcd", acc_bcd, 16'h4921);

        // illegal digit1 pattern
        scan(16'h43F1, 6, 4);
        scan(16'h43F1, 6, 4);
        idle(4);
        chk("ill_acc", acc_cnt, 3);
        chk("ill_bcd", bcd_out, 16'h43F1);
        chk("ill_err", err, ERR_EN ? 5'b00010 : 5'b00000);

        // overrun while stalled
        ready = 1'b0;
        scan(16'h4321, 6, 4);
        scan(16'h4321, 6, 4);
        idle(4);
        chk("stall_valid", valid, 1'b1);
        chk("stall_bcd", bcd_out, 16'h4321);
        scan(16'h5321, 6, 4);
        scan(16'h5321, 6, 4);
        idle(4);
        chk("ovr_bcd", bcd_out, 16'h4321);
        chk("ovr_valid", valid, 1'b1);
        chk("ovr_err", err, ERR_EN ? 5'b10010 : 5'b00000);
        ready = 1'b1;
        cyc();
        chk("release_valid", valid, 1'b0);
        chk("release_acc", acc_cnt, 4);
        chk("release_bcd", acc_bcd, 16'h4321);

        // reset mid-scan after three digits
        scan(16'h8765, 6, 3);
        #3;
        rst_n  = 1'b0;
        dig_n  = 4'hF;
        seg_in = 7'h7F;
        #1;
        chk("amid_bcd", bcd_out, 16'h0000);
        chk("amid_valid", valid, 1'b0);
        chk("amid_err", err, 5'b0);
        chk("amid_seen", dut.seen_q, 4'h0);
        cyc();
        rst_n = 1'b1;
        idle(2);
        scan(16'h4321, 6, 4);
        idle(4);
        chk("post1_acc", acc_cnt, 4);
        chk("post1_valid", valid, 1'b0);
        scan(16'h4321, 6, 4);
        idle(4);
        chk("post2_acc", acc_cnt, 5);
        chk("post2_bcd", acc_bcd, 16'h4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
